// File: rtl/queue_arb_pkg.sv
// rtl/queue_arb_pkg.sv - shared defaults, opcodes and FSM encoding for queue_arbiter
`timescale 1ns/1ps
package queue_arb_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 8;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_e;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/queue_arbiter_if.sv
// rtl/queue_arbiter_if.sv - queue access bus between the arbiter (master) and the queue (slave)
`timescale 1ns/1ps
interface queue_arbiter_if #(
  parameter int WIDTH = 4
) ();

  logic             q_enable;
  logic             q_push_pop;
  logic [WIDTH-1:0] q_data_in;
  logic [WIDTH-1:0] q_data_out;

  modport master (
    output q_enable,
    output q_push_pop,
    output q_data_in,
    input  q_data_out
  );

  modport slave (
    input  q_enable,
    input  q_push_pop,
    input  q_data_in,
    output q_data_out
  );

endinterface

// File: rtl/queue_arbiter_rr_arb2.sv
// rtl/queue_arbiter_rr_arb2.sv - two-way round-robin winner select (ptr breaks ties)
`timescale 1ns/1ps
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = (req[0] & req[1]) ? ptr : req[1];
  end

endmodule

// File: rtl/queue_arbiter.sv
// rtl/queue_arbiter.sv - round-robin push/pop arbiter for one shared queue; QUEUE_ARB_STATS_EN adds rej_cnt
`timescale 1ns/1ps
module queue_arbiter
  import queue_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    din0,
  input  logic [WIDTH-1:0]    din1,
  queue_arbiter_if.master     q_bus,
  output logic [1:0]          done,
  output logic [1:0]          rej,
  output logic [WIDTH-1:0]    rdata,
  output logic                full,
  output logic                empty
`ifdef QUEUE_ARB_STATS_EN
  ,
  output logic [7:0]          rej_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]       rej_c;

  logic             winner;
  logic             win_valid;
  logic             win_op;
  logic [WIDTH-1:0] win_data;
  logic             win_legal;

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_op    = op[winner];
    win_data  = winner ? din1 : din0;
    win_legal = (win_op == OP_PUSH) ? (count_q != CW'(DEPTH)) : (count_q != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rr_ptr_q <= 1'b0;
      op_q     <= OP_POP;
      id_q     <= 1'b0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      id_q     <= id_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    id_d     = id_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    rej_c    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          // Fairness pointer moves away from whoever was just served or refused.
          rr_ptr_d = ~winner;
          if (win_legal) begin
            op_d    = win_op;
            id_d    = winner;
            data_d  = win_data;
            state_d = ST_ISSUE;
          end else begin
            rej_c = id_onehot(winner);
          end
        end
      end
      ST_ISSUE: begin
        count_d = (op_q == OP_PUSH) ? count_q + CW'(1) : count_q - CW'(1);
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (op_q == OP_POP) rdata_d = q_bus.q_data_out;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    q_bus.q_enable   = (state_q == ST_ISSUE);
    q_bus.q_push_pop = (state_q == ST_ISSUE) ? op_q : OP_POP;
    q_bus.q_data_in  = (state_q == ST_ISSUE) ? data_q : '0;
    done             = (state_q == ST_CAPTURE) ? id_onehot(id_q) : 2'b00;
    // Rejection is combinational from req, so it must be masked while reset is held.
    rej              = reset ? rej_c : 2'b00;
    // Popped data is forwarded during CAPTURE so it lines up with the done pulse.
    rdata            = (state_q == ST_CAPTURE && op_q == OP_POP) ? q_bus.q_data_out : rdata_q;
    full             = (count_q == CW'(DEPTH));
    empty            = (count_q == '0);
  end

`ifdef QUEUE_ARB_STATS_EN
  logic [7:0] rej_cnt_q, rej_cnt_d;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if ((|rej) && (rej_cnt_q != 8'hFF)) rej_cnt_d = rej_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rej_cnt_q <= '0;
    else        rej_cnt_q <= rej_cnt_d;
  end

  assign rej_cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_queue_arbiter.sv
// tb/tb_queue_arbiter.sv - directed self-checking bench for queue_arbiter with a queue model
`timescale 1ns/1ps
module tb_queue_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] op;
  logic [3:0] din0, din1;
  logic [1:0] done, rej;
  logic [3:0] rdata;
  logic       full, empty;
`ifdef QUEUE_ARB_STATS_EN
  logic [7:0] rej_cnt;
`endif

  int checks = 0;
  int errors = 0;

  queue_arbiter_if #(.WIDTH(4)) qbus ();

  queue_arbiter #(.WIDTH(4), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .op    (op),
    .din0  (din0),
    .din1  (din1),
    .q_bus (qbus),
    .done  (done),
    .rej   (rej),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
`ifdef QUEUE_ARB_STATS_EN
    ,
    .rej_cnt (rej_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] qmem[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qmem.delete();
      qbus.q_data_out <= 4'h0;
    end else if (qbus.q_enable) begin
      if (qbus.q_push_pop) qmem.push_back(qbus.q_data_in);
      else if (qmem.size() > 0) qbus.q_data_out <= qmem.pop_front();
    end
  end

  logic [1:0] s_rej, s_done;
  logic       s_qen_t, s_qen, s_pp;
  logic [3:0] s_qdi, s_rdata;

  task automatic do_reset();
    reset = 1'b0;
    req   = 2'b00;
    op    = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_req(input logic [1:0] r, input logic [1:0] o,
                         input logic [3:0] d0, input logic [3:0] d1);
    @(negedge clk);
    req = r; op = o; din0 = d0; din1 = d1;
    #1;
    s_rej   = rej;
    s_qen_t = qbus.q_enable;
    @(posedge clk); #1;
    req   = 2'b00;
    s_qen = qbus.q_enable;
    s_pp  = qbus.q_push_pop;
    s_qdi = qbus.q_data_in;
    if (s_rej != 2'b00) begin
      s_done  = done;
      s_rdata = rdata;
    end else begin
      @(posedge clk); #1;
      s_done  = done;
      s_rdata = rdata;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 2'b01;
    op    = 2'b00;
    #12;
    checks++; if (qbus.q_enable !== 1'b0) begin errors++; $display("FAIL reset_qen: got %b expected 0", qbus.q_enable); end
    checks++; if (qbus.q_data_in !== 4'h0) begin errors++; $display("FAIL reset_qdi: got %h expected 0", qbus.q_data_in); end
    checks++; if (rej !== 2'b00) begin errors++; $display("FAIL reset_rej: got %b expected 00", rej); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", done); end
    checks++; if (rdata !== 4'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if ({full, empty} !== 2'b01) begin errors++; $display("FAIL reset_full_empty: got %b expected 01", {full, empty}); end
    do_reset();
  endtask

  task automatic test_push_single();
    do_reset();
    run_req(2'b01, 2'b01, 4'hA, 4'h0);
    checks++; if (s_rej !== 2'b00) begin errors++; $display("FAIL push1_rej: got %b expected 00", s_rej); end
    checks++; if (s_qen_t !== 1'b0) begin errors++; $display("FAIL push1_qen_t0: got %b expected 0", s_qen_t); end
    checks++; if ({s_qen, s_pp, s_qdi} !== {1'b1, 1'b1, 4'hA}) begin errors++; $display("FAIL push1_issue: got %b%b%h expected 11a", s_qen, s_pp, s_qdi); end
    checks++; if (s_done !== 2'b01) begin errors++; $display("FAIL push1_done: got %b expected 01", s_done); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL push1_empty: got %b expected 0", empty); end
    checks++; if (qbus.q_enable !== 1'b0) begin errors++; $display("FAIL push1_qen_idle: got %b expected 0", qbus.q_enable); end
  endtask

  task automatic test_pop_empty();
    do_reset();
    run_req(2'b01, 2'b00, 4'h0, 4'h0);
    checks++; if (s_rej !== 2'b01) begin errors++; $display("FAIL popempty_rej: got %b expected 01", s_rej); end
    checks++; if ({s_qen_t, s_qen} !== 2'b00) begin errors++; $display("FAIL popempty_qen: got %b expected 00", {s_qen_t, s_qen}); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL popempty_empty: got %b expected 1", empty); end
    run_req(2'b11, 2'b11, 4'h1, 4'h2);
    checks++; if (s_done !== 2'b10) begin errors++; $display("FAIL ptr_after_rej_done: got %b expected 10", s_done); end
    checks++; if (s_qdi !== 4'h2) begin errors++; $display("FAIL ptr_after_rej_qdi: got %h expected 2", s_qdi); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_req(2'b01, 2'b01, 4'(i), 4'h0);
      if (i == 6) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_7: got %b expected 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_8: got %b expected 1", full); end
    run_req(2'b01, 2'b01, 4'hF, 4'h0);
    checks++; if (s_rej !== 2'b01) begin errors++; $display("FAIL fill_rej_9: got %b expected 01", s_rej); end
    checks++; if ({s_qen_t, s_qen} !== 2'b00) begin errors++; $display("FAIL fill_qen_9: got %b expected 00", {s_qen_t, s_qen}); end
    checks++; if (qmem.size() !== 8) begin errors++; $display("FAIL fill_qsize: got %0d expected 8", qmem.size()); end
`ifdef QUEUE_ARB_STATS_EN
    checks++; if (rej_cnt !== 8'd1) begin errors++; $display("FAIL fill_rej_cnt: got %0d expected 1", rej_cnt); end
`endif
  endtask

  task automatic test_fifo_pop();
    do_reset();
    run_req(2'b01, 2'b01, 4'h3, 4'h0);
    run_req(2'b01, 2'b01, 4'h5, 4'h0);
    run_req(2'b10, 2'b00, 4'h0, 4'h0);
    checks++; if ({s_done, s_rdata} !== {2'b10, 4'h3}) begin errors++; $display("FAIL pop1: got done=%b rdata=%h expected done=10 rdata=3", s_done, s_rdata); end
    run_req(2'b10, 2'b00, 4'h0, 4'h0);
    checks++; if ({s_done, s_rdata} !== {2'b10, 4'h5}) begin errors++; $display("FAIL pop2: got done=%b rdata=%h expected done=10 rdata=5", s_done, s_rdata); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pop_empty_after: got %b expected 1", empty); end
    run_req(2'b01, 2'b01, 4'h7, 4'h0);
    checks++; if ({s_done, s_rdata, rdata} !== {2'b01, 4'h5, 4'h5}) begin errors++; $display("FAIL rdata_hold: got done=%b rdata=%h/%h expected done=01 rdata=5/5", s_done, s_rdata, rdata); end
  endtask

  task automatic test_alternate();
    logic [1:0] seen[4];
    int         n;
    do_reset();
    n = 0;
    @(negedge clk);
    req = 2'b11; op = 2'b11; din0 = 4'h1; din1 = 4'h2;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (done != 2'b00) begin
        if (n < 4) seen[n] = done;
        n++;
      end
    end
    req = 2'b00;
    @(posedge clk); #1;
    checks++; if (n !== 4) begin errors++; $display("FAIL alt_count: got %0d expected 4", n); end
    checks++; if ({seen[0], seen[1], seen[2], seen[3]} !== 8'b01_10_01_10) begin errors++; $display("FAIL alt_order: got %b %b %b %b expected 01 10 01 10", seen[0], seen[1], seen[2], seen[3]); end
  endtask

  task automatic test_reset_issue();
    do_reset();
    @(negedge clk);
    req = 2'b01; op = 2'b01; din0 = 4'h6;
    @(posedge clk); #1;
    req = 2'b00;
    checks++; if (qbus.q_enable !== 1'b1) begin errors++; $display("FAIL rst_issue_qen: got %b expected 1", qbus.q_enable); end
    reset = 1'b0;
    #1;
    checks++; if ({qbus.q_enable, empty, done} !== 4'b0100) begin errors++; $display("FAIL rst_issue_abort: got qen=%b empty=%b done=%b expected 0 1 00", qbus.q_enable, empty, done); end
    @(posedge clk); #1;
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL rst_issue_nodone: got %b expected 00", done); end
    @(negedge clk);
    reset = 1'b1;
    run_req(2'b01, 2'b01, 4'hB, 4'h0);
    checks++; if ({s_rej, s_qen, s_qdi, s_done} !== {2'b00, 1'b1, 4'hB, 2'b01}) begin errors++; $display("FAIL rst_issue_next: got rej=%b qen=%b qdi=%h done=%b expected 00 1 b 01", s_rej, s_qen, s_qdi, s_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = 2'b00; op = 2'b00; din0 = 4'h0; din1 = 4'h0;
    test_reset();
    test_push_single();
    test_pop_empty();
    test_fill();
    test_fifo_pop();
    test_alternate();
    test_reset_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, shall set the queue data width.
REQ-002 Parameter DEPTH, default 8, shall set the queue entry count used for the occupancy limit.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  shall be the asynchronous, active-low reset.
REQ-005 req  input  2  shall carry one request bit per requester (0, 1).
REQ-006 op  input  2  shall carry the per-requester operation: 1 = push, 0 = pop.
REQ-007 din0, din1  input  WIDTH  shall carry each requester's push data.
REQ-008 q_data_out  input  WIDTH  shall carry the queue's read data.
REQ-009 q_enable  output  1  shall be the queue access strobe.
REQ-010 q_push_pop  output  1  shall be the queue operation: 1 = push, 0 = pop.
REQ-011 q_data_in  output  WIDTH  shall carry push data to the queue.
REQ-012 done  output  2  shall be a one-cycle per-requester completion pulse.
REQ-013 rej  output  2  shall be a one-cycle per-requester rejection pulse.
REQ-014 rdata  output  WIDTH  shall carry the captured pop data.
REQ-015 full, empty  output  1 each  shall reflect the arbiter's occupancy count.

Function
REQ-016 The FSM shall have states IDLE, ISSUE and CAPTURE.
REQ-017 In IDLE, with any req bit high, the block shall pick one winner round-robin; when both are high, priority goes to the requester indicated by rr_ptr.
REQ-018 An illegal winner (push with count==DEPTH, or pop with count==0) shall get rej[i] for one cycle in that IDLE cycle; there is no queue access and the FSM stays in IDLE.
REQ-019 A legal winner shall have its op, data and id registered, and the FSM shall move to ISSUE.
REQ-020 ISSUE shall hold q_enable=1 for exactly one cycle, with q_push_pop and q_data_in from the registered values, then move to CAPTURE.
REQ-021 In CAPTURE, a pop shall load rdata from q_data_out; done[id] shall pulse for one cycle; the FSM shall return to IDLE.
REQ-022 Latency from the IDLE sampling cycle t shall be: q_enable at t+1, done at t+2, next arbitration at t+3.
REQ-023 After every grant or rejection, rr_ptr shall point to the other requester.
REQ-024 The count shall increment on a push and decrement on a pop, in the ISSUE cycle, with range 0..DEPTH; full = (count==DEPTH) and empty = (count==0), both combinational from count.
REQ-025 req shall be sampled only in IDLE; a requester shall drop req in the cycle it sees done or rej, otherwise it is treated as a new request.
REQ-026 rdata shall hold its value until the next pop completes; push completions leave it unchanged.
REQ-027 When not in ISSUE, q_enable shall be 0.

Reset
REQ-028 reset low shall immediately force: IDLE, count=0, rr_ptr=0, q_enable=0, q_push_pop=0, q_data_in=0, done=0, rej=0, rdata=0, full=0, empty=1.
REQ-029 Reset asserted in ISSUE or CAPTURE shall abort the access with no done pulse; the queue shares the same reset, so occupancy stays consistent.

Configuration
REQ-030 With QUEUE_ARB_STATS_EN defined, output rej_cnt[7:0] shall count rej pulses (both requesters, simultaneous counts 1 per cycle), saturating at 255, and reset to 0.
REQ-031 Without QUEUE_ARB_STATS_EN, the rej_cnt port and its logic shall be absent; all other behaviour is identical.

Structure
REQ-032 Package queue_arb_pkg shall hold WIDTH/DEPTH defaults, OP_PUSH=1/OP_POP=0 and the FSM state encoding.
REQ-033 The round-robin winner selection shall be sub-module rr_arb2 (inputs: req[1:0], ptr; outputs: winner id, valid).

Verification
REQ-034 Reset, then req=01, op=1, din0=4'hA -> q_enable at t+1 with q_push_pop=1 and q_data_in=A; done=01 at t+2; empty=0.
REQ-035 Eight pushes, then one more push -> full=1 after the 8th push, rej pulse on the 9th push with no q_enable; rej_cnt=1 when STATS is enabled.
REQ-036 Pop with count=0 -> rej pulse, q_enable stays 0, empty=1.
REQ-037 Both requesters request continuously (pushes, not full) -> grants alternate 0,1,0,1 starting with requester 0 after reset.
REQ-038 Push 3, 5, then pops by requester 1 with a queue model -> rdata=3 then rdata=5, each coinciding with done=10.
REQ-039 reset asserted during ISSUE -> no done pulse, count=0 and the FSM in IDLE immediately; the next request is serviced normally.
